// File: rtl/alu_result_checker.sv
// Response checker for the 32-bit XOR ALU: recomputes the golden result and flags,
// counts passes/fails over a run of vectors and captures the first failing vector.
module alu_result_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_vec,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_eq,
  input  logic             i_cary,
  input  logic             i_of,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic [WIDTH-1:0] o_first_a,
  output logic [WIDTH-1:0] o_first_b,
  output logic [WIDTH-1:0] o_first_s,
  output logic [3:0]       o_fail_mask
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] DAT_ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Mask bits {s, eq, cary, of}; a set bit means that field disagrees with the XOR golden model.
  function automatic logic [3:0] calc_mask(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] s,
    input logic             eq,
    input logic             cary,
    input logic             of
  );
    logic [WIDTH-1:0] exp_s;
    logic             exp_eq;
    exp_s  = a ^ b;
    exp_eq = (a == b);
    calc_mask = {(s != exp_s), (eq != exp_eq), (cary != 1'b0), (of != 1'b0)};
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_num_vec;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH-1:0] r_s1_s;
  logic             r_s1_eq;
  logic             r_s1_cary;
  logic             r_s1_of;

  logic             r_s2_valid;
  logic [3:0]       r_s2_mask;
  logic [WIDTH-1:0] r_s2_a;
  logic [WIDTH-1:0] r_s2_b;
  logic [WIDTH-1:0] r_s2_s;

  logic             r_err;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [WIDTH-1:0] r_first_a;
  logic [WIDTH-1:0] r_first_b;
  logic [WIDTH-1:0] r_first_s;
  logic [3:0]       r_fail_mask;

  logic w_accept;
  logic w_start_ok;

  assign w_accept   = r_in_ready & i_in_valid;
  assign w_start_ok = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_num_vec  <= CNT_ZERO;
      r_acc_cnt  <= CNT_ZERO;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_num_vec <= i_num_vec;
            r_acc_cnt <= CNT_ZERO;
            if (i_num_vec == CNT_ZERO) begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state    <= ST_RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + CNT_ONE;
            if ((r_acc_cnt + CNT_ONE) == r_num_vec) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // Stage 2 retires on this same edge, so counts are final when done rises.
          if (!r_s1_valid) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= DAT_ZERO;
      r_s1_b     <= DAT_ZERO;
      r_s1_s     <= DAT_ZERO;
      r_s1_eq    <= 1'b0;
      r_s1_cary  <= 1'b0;
      r_s1_of    <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a    <= i_a;
        r_s1_b    <= i_b;
        r_s1_s    <= i_s;
        r_s1_eq   <= i_eq;
        r_s1_cary <= i_cary;
        r_s1_of   <= i_of;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_valid <= 1'b0;
      r_s2_mask  <= 4'b0000;
      r_s2_a     <= DAT_ZERO;
      r_s2_b     <= DAT_ZERO;
      r_s2_s     <= DAT_ZERO;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mask <= calc_mask(r_s1_a, r_s1_b, r_s1_s, r_s1_eq, r_s1_cary, r_s1_of);
        r_s2_a    <= r_s1_a;
        r_s2_b    <= r_s1_b;
        r_s2_s    <= r_s1_s;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err       <= 1'b0;
      r_pass_cnt  <= CNT_ZERO;
      r_fail_cnt  <= CNT_ZERO;
      r_first_a   <= DAT_ZERO;
      r_first_b   <= DAT_ZERO;
      r_first_s   <= DAT_ZERO;
      r_fail_mask <= 4'b0000;
    end else if (w_start_ok) begin
      r_err       <= 1'b0;
      r_pass_cnt  <= CNT_ZERO;
      r_fail_cnt  <= CNT_ZERO;
      r_first_a   <= DAT_ZERO;
      r_first_b   <= DAT_ZERO;
      r_first_s   <= DAT_ZERO;
      r_fail_mask <= 4'b0000;
    end else if (r_s2_valid) begin
      if (r_s2_mask == 4'b0000) begin
        if (r_pass_cnt != CNT_MAX) begin
          r_pass_cnt <= r_pass_cnt + CNT_ONE;
        end
      end else begin
        r_err <= 1'b1;
        if (r_fail_cnt != CNT_MAX) begin
          r_fail_cnt <= r_fail_cnt + CNT_ONE;
        end
        // Only the first failure of a run is captured.
        if (r_fail_cnt == CNT_ZERO) begin
          r_first_a   <= r_s2_a;
          r_first_b   <= r_s2_b;
          r_first_s   <= r_s2_s;
          r_fail_mask <= r_s2_mask;
        end
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_pass_cnt  = r_pass_cnt;
  assign o_fail_cnt  = r_fail_cnt;
  assign o_first_a   = r_first_a;
  assign o_first_b   = r_first_b;
  assign o_first_s   = r_first_s;
  assign o_fail_mask = r_fail_mask;

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: run summaries are queued at start and
// compared by a monitor when done rises; timing and reset checks are inline.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b, s;
  logic        eq, cary, of;
  logic        busy, done, err;
  logic [15:0] pass_cnt, fail_cnt;
  logic [31:0] first_a, first_b, first_s;
  logic [3:0]  fail_mask;

  typedef struct {
    logic [15:0] pass_n;
    logic [15:0] fail_n;
    logic        err;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] fs;
    logic [3:0]  mask;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_done = 1'b0;

  alu_result_checker #(.WIDTH(32), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_vec(num_vec),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_s(s), .i_eq(eq), .i_cary(cary), .i_of(of),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt),
    .o_first_a(first_a), .o_first_b(first_b), .o_first_s(first_s),
    .o_fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_cnts"},  {pass_cnt, fail_cnt}, 32'd0);
    check({tag, "_first"}, first_a | first_b | first_s, 32'd0);
    check({tag, "_mask"},  32'(fail_mask), 32'd0);
  endtask

  task automatic push_exp(input logic [15:0] p, input logic [15:0] f, input logic e,
                          input logic [31:0] fa, input logic [31:0] fb, input logic [31:0] fs,
                          input logic [3:0] m);
    exp_t x;
    x.pass_n = p; x.fail_n = f; x.err = e; x.fa = fa; x.fb = fb; x.fs = fs; x.mask = m;
    sb_q.push_back(x);
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic start_run(input logic [15:0] n);
    start = 1'b1;
    num_vec = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic put(input logic v, input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] vs, input logic veq, input logic vc, input logic vo);
    in_valid = v; a = va; b = vb; s = vs; eq = veq; cary = vc; of = vo;
    if (v) check("ready_on_put", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  // Monitor: a rising done presents a run result to compare against the queue head.
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        check("mon_pass_cnt", 32'(pass_cnt), 32'(x.pass_n));
        check("mon_fail_cnt", 32'(fail_cnt), 32'(x.fail_n));
        check("mon_err", 32'(err), 32'(x.err));
        check("mon_first_a", first_a, x.fa);
        check("mon_first_b", first_b, x.fb);
        check("mon_first_s", first_s, x.fs);
        check("mon_fail_mask", 32'(fail_mask), 32'(x.mask));
      end
    end
    prev_done <= done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_vec = 16'd0; in_valid = 1'b0;
    a = 32'd0; b = 32'd0; s = 32'd0; eq = 1'b0; cary = 1'b0; of = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Empty run: done the next cycle, never busy.
    push_exp(16'd0, 16'd0, 1'b0, 32'd0, 32'd0, 32'd0, 4'b0000);
    start_run(16'd0);
    check("nv0_done", 32'(done), 32'd1);
    check("nv0_busy", 32'(busy), 32'd0);
    check("nv0_cnts", {pass_cnt, fail_cnt}, 32'd0);
    @(negedge clk);
    check("nv0_busy2", 32'(busy), 32'd0);

    // Six correct back-to-back vectors.
    push_exp(16'd6, 16'd0, 1'b0, 32'd0, 32'd0, 32'd0, 4'b0000);
    start_run(16'd6);
    check("run6_busy", 32'(busy), 32'd1);
    put(1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
    put(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
    put(1'b1, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    put(1'b1, 32'h00000000, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0);
    put(1'b1, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    put(1'b1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    check("run6_ready_drop", 32'(in_ready), 32'd0);
    check("run6_done_n0", 32'(done), 32'd0);
    @(negedge clk);
    check("run6_done_n1", 32'(done), 32'd0);
    @(negedge clk);
    check("run6_done_n2", 32'(done), 32'd1);
    check("run6_busy_end", 32'(busy), 32'd0);

    // One bad result in the middle of three.
    push_exp(16'd2, 16'd1, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000, 4'b1000);
    start_run(16'd3);
    put(1'b1, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0);
    put(1'b1, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 1'b0);
    put(1'b1, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b0);
    wait_done();

    // Two failures: only the first one is captured.
    push_exp(16'd0, 16'd2, 1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 4'b0100);
    start_run(16'd2);
    put(1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b0);
    put(1'b1, 32'h00000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1);
    wait_done();

    // Gapped valid with garbage on idle cycles and an ignored mid-run start.
    push_exp(16'd2, 16'd0, 1'b0, 32'd0, 32'd0, 32'd0, 4'b0000);
    start_run(16'd2);
    put(1'b1, 32'h00000003, 32'h00000005, 32'h00000006, 1'b0, 1'b0, 1'b0);
    start = 1'b1; num_vec = 16'd9;
    put(1'b0, 32'hDEADBEEF, 32'h00000000, 32'h00001234, 1'b1, 1'b1, 1'b1);
    start = 1'b0;
    check("gap_busy", 32'(busy), 32'd1);
    put(1'b1, 32'h0000000A, 32'h0000000A, 32'h00000000, 1'b1, 1'b0, 1'b0);
    put(1'b0, 32'hDEADBEEF, 32'h00000000, 32'h00001234, 1'b1, 1'b1, 1'b1);
    wait_done();
    check("gap_total", 32'(pass_cnt) + 32'(fail_cnt), 32'd2);

    // Reset with vectors in flight, then a clean run.
    push_exp(16'd5, 16'd0, 1'b0, 32'd0, 32'd0, 32'd0, 4'b0000);
    start_run(16'd5);
    put(1'b1, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0);
    put(1'b1, 32'h00000002, 32'h00000000, 32'h00000002, 1'b0, 1'b0, 1'b0);
    put(1'b1, 32'h00000004, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_rst");
    push_exp(16'd1, 16'd1, 1'b1, 32'h00000002, 32'h00000003, 32'h00000001, 4'b0010);
    start_run(16'd2);
    put(1'b1, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0);
    put(1'b1, 32'h00000002, 32'h00000003, 32'h00000001, 1'b0, 1'b1, 1'b0);
    wait_done();

    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
